// File: rtl/timer_event_ctrl.sv
// Tick-threshold event controller: counts timer ticks against a latched threshold
// and raises a level interrupt in one-shot or periodic mode, tracking missed events.
module timer_event_ctrl #(
    parameter int CNT_WIDTH  = 16,
    parameter int MISS_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  tick_i,
    input  logic                  cfg_en_i,
    input  logic                  cfg_mode_i,
    input  logic [CNT_WIDTH-1:0]  cfg_thresh_i,
    input  logic                  start_i,
    input  logic                  irq_ack_i,
    input  logic                  miss_clr_i,
    output logic                  irq_o,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  cnt_o,
    output logic [MISS_WIDTH-1:0] miss_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [MISS_WIDTH-1:0] MISS_MAX = {MISS_WIDTH{1'b1}};
    localparam logic [MISS_WIDTH-1:0] MISS_ONE = {{(MISS_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_r, state_s;
    logic [CNT_WIDTH-1:0]    cnt_r, cnt_s;
    logic [CNT_WIDTH-1:0]    thr_r, thr_s;
    logic [CNT_WIDTH-1:0]    last_s;
    logic                    irq_r, irq_s;
    logic                    busy_r;
    logic [MISS_WIDTH-1:0]   miss_r, miss_s;
    logic                    event_s;
    logic                    miss_inc_s;

    // Next-state, counter and threshold-latch decode
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        thr_s   = thr_r;
        event_s = 1'b0;
        // Threshold 0 behaves as a period of 1, so the last count index is 0
        if (thr_r == CNT_ZERO) begin
            last_s = CNT_ZERO;
        end else begin
            last_s = thr_r - CNT_ONE;
        end
        case (state_r)
            ST_IDLE: begin
                if (start_i && cfg_en_i) begin
                    state_s = ST_RUN;
                    cnt_s   = CNT_ZERO;
                    thr_s   = cfg_thresh_i;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!cfg_en_i) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else if (start_i) begin
                    cnt_s = CNT_ZERO;
                    thr_s = cfg_thresh_i;
                end else if (tick_i) begin
                    if (cnt_r == last_s) begin
                        event_s = 1'b1;
                        cnt_s   = CNT_ZERO;
                        if (!cfg_mode_i) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_DONE: begin
                if (!cfg_en_i) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else if (start_i) begin
                    state_s = ST_RUN;
                    cnt_s   = CNT_ZERO;
                    thr_s   = cfg_thresh_i;
                end else begin
                    cnt_s = CNT_ZERO;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Interrupt pending flag and saturating missed-event counter
    always_comb begin
        irq_s      = irq_r;
        miss_s     = miss_r;
        // An ack arriving with a new event consumes the old one, so no miss
        miss_inc_s = event_s && irq_r && !irq_ack_i;
        if (event_s) begin
            irq_s = 1'b1;
        end else if (irq_ack_i) begin
            irq_s = 1'b0;
        end else begin
            irq_s = irq_r;
        end
        if (miss_clr_i) begin
            miss_s = miss_inc_s ? MISS_ONE : {MISS_WIDTH{1'b0}};
        end else if (miss_inc_s && (miss_r != MISS_MAX)) begin
            miss_s = miss_r + MISS_ONE;
        end else begin
            miss_s = miss_r;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            thr_r   <= CNT_ZERO;
            irq_r   <= 1'b0;
            busy_r  <= 1'b0;
            miss_r  <= {MISS_WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            thr_r   <= thr_s;
            irq_r   <= irq_s;
            busy_r  <= (state_s == ST_RUN);
            miss_r  <= miss_s;
        end
    end

    assign irq_o  = irq_r;
    assign busy_o = busy_r;
    assign cnt_o  = cnt_r;
    assign miss_o = miss_r;

endmodule

// File: tb/tb_timer_event_ctrl.sv
// Directed bench for timer_event_ctrl: vector table for one-shot/periodic flows,
// hand-written sequences for saturation, restart, enable drop and async reset.
module tb_timer_event_ctrl;

    localparam int CW = 16;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tick, en, mode, start, ack, clr;
    logic [CW-1:0] thr;
    logic          irq, busy;
    logic [CW-1:0] cnt;
    logic [MW-1:0] miss;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic          tick, start, ack, clr, en, mode;
        logic [CW-1:0] thr;
        logic          e_irq, e_busy;
        logic [CW-1:0] e_cnt;
        logic [MW-1:0] e_miss;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    timer_event_ctrl #(.CNT_WIDTH(CW), .MISS_WIDTH(MW)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .tick_i       (tick),
        .cfg_en_i     (en),
        .cfg_mode_i   (mode),
        .cfg_thresh_i (thr),
        .start_i      (start),
        .irq_ack_i    (ack),
        .miss_clr_i   (clr),
        .irq_o        (irq),
        .busy_o       (busy),
        .cnt_o        (cnt),
        .miss_o       (miss)
    );

    function automatic void add(logic t, logic s, logic a, logic c, logic e, logic m,
                                int th, logic ei, logic eb, int ec, int em);
        vec_t v;
        v.tick = t; v.start = s; v.ack = a; v.clr = c; v.en = e; v.mode = m;
        v.thr = CW'(th); v.e_irq = ei; v.e_busy = eb; v.e_cnt = CW'(ec); v.e_miss = MW'(em);
        vecs.push_back(v);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic t, logic s, logic a, logic c);
        tick = t; start = s; ack = a; clr = c;
    endtask

    task automatic chk(string nm, logic ei, logic eb, int ec, int em);
        n_cmp++;
        if (irq !== ei || busy !== eb || cnt !== CW'(ec) || miss !== MW'(em)) begin
            n_err++;
            $display("FAIL %s: got irq=%b busy=%b cnt=%0d miss=%0d, want irq=%b busy=%b cnt=%0d miss=%0d",
                     nm, irq, busy, cnt, miss, ei, eb, ec, em);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; thr = '0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // One-shot, threshold 5, ticks spaced 3 cycles apart
        add(0, 1, 0, 0, 1, 0, 5, 0, 1, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            add(1, 0, 0, 0, 1, 0, 5, (k == 5), (k < 5), k % 5, 0);
            add(0, 0, 0, 0, 1, 0, 5, (k == 5), (k < 5), k % 5, 0);
            add(0, 0, 0, 0, 1, 0, 5, (k == 5), (k < 5), k % 5, 0);
        end
        add(1, 0, 0, 0, 1, 0, 5, 1, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 5, 1, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 5, 0, 0, 0, 0);
        // Periodic, threshold 3, tick held 9 cycles, ack one cycle after each rise
        add(0, 1, 0, 0, 1, 1, 3, 0, 1, 0, 0);
        for (int t = 1; t <= 9; t++) begin
            add(1, 0, (t == 4 || t == 7), 0, 1, 1, 3, (t % 3 == 0), 1, t % 3, 0);
        end
        add(0, 0, 1, 0, 1, 1, 3, 0, 1, 0, 0);

        #12;
        chk("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            tick = vecs[i].tick; start = vecs[i].start; ack = vecs[i].ack;
            clr = vecs[i].clr; en = vecs[i].en; mode = vecs[i].mode; thr = vecs[i].thr;
            cyc();
            chk($sformatf("vec%0d", i), vecs[i].e_irq, vecs[i].e_busy,
                int'(vecs[i].e_cnt), int'(vecs[i].e_miss));
        end

        // Missed events: period 1, tick held 300 cycles, no ack
        en = 1'b1; mode = 1'b1; thr = CW'(1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        chk("sat_start", 0, 1, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 300; k++) begin
            cyc();
            chk($sformatf("sat_k%0d", k), 1, 1, 0, (k - 1 > 255) ? 255 : k - 1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        cyc();
        chk("miss_clr", 1, 1, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        cyc();
        chk("clr_with_inc", 1, 1, 0, 1);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        cyc();
        chk("event_with_ack", 1, 1, 0, 1);

        // Restart with tick discarded and new threshold 0
        thr = CW'(4);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        cyc();
        chk("restart_thr4", 0, 1, 0, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("thr4_tick1", 0, 1, 1, 1);
        cyc();
        chk("thr4_tick2", 0, 1, 2, 1);
        thr = CW'(0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        chk("restart_tick_discard", 0, 1, 0, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("thr0_event", 1, 1, 0, 1);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        cyc();
        chk("thr0_event_ack", 1, 1, 0, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("thr0_miss", 1, 1, 0, 2);

        // Enable drop mid-RUN with irq pending
        thr = CW'(4);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        chk("drop_start", 1, 1, 0, 2);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();
        chk("drop_cnt2", 1, 1, 2, 2);
        en = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        chk("en_drop", 1, 0, 0, 2);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        chk("start_disabled", 1, 0, 0, 2);
        en = 1'b1;
        cyc();
        chk("start_reenabled", 1, 1, 0, 2);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("pre_reset_cnt1", 1, 1, 1, 2);

        // Asynchronous reset mid-RUN
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 0, 0, 0, 0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();
        chk("post_reset_idle", 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/timer_event_ctrl.md
# timer_event_ctrl

Downstream consumer of the free-running timer's tick pulse. Counts incoming ticks against a programmable threshold. Raises a level interrupt when the threshold is reached, in one-shot or periodic mode. Tracks events lost while the interrupt is still pending. Sits between the timer core and the interrupt controller / register bank.

## Interface
- `CNT_WIDTH`, default 16: width of the tick counter and threshold.
- `MISS_WIDTH`, default 8: width of the saturating missed-event counter.

Ports:
- `clk_i`  in  1  system clock.
- `rst_n_i`  in  1  reset; one clock, asynchronous and active-low.
- `tick_i`  in  1  single-cycle tick pulse from the timer; may be high on consecutive cycles.
- `cfg_en_i`  in  1  block enable level.
- `cfg_mode_i`  in  1  0 = one-shot, 1 = periodic.
- `cfg_thresh_i`  in  CNT_WIDTH  ticks per event; sampled only on accepted `start_i`.
- `start_i`  in  1  single-cycle launch/restart pulse.
- `irq_ack_i`  in  1  single-cycle interrupt acknowledge.
- `miss_clr_i`  in  1  single-cycle clear for `miss_o`.
- `irq_o`  out  1  interrupt pending, level.
- `busy_o`  out  1  high in RUN.
- `cnt_o`  out  CNT_WIDTH  current tick count within the period.
- `miss_o`  out  MISS_WIDTH  saturating count of events lost while `irq_o` was pending.

## Operation
- **Reset values.** All outputs and state reset to 0: state IDLE, `thr_q` = 0.
- **States.** IDLE, RUN, DONE. `busy_o` = (state == RUN).
- **Threshold latch.** `thr_q` latches `cfg_thresh_i` on every accepted start. Effective period = max(`thr_q`, 1); threshold 0 behaves as 1.
- **IDLE.**
  - `start_i` & `cfg_en_i` → RUN; `cnt` ← 0; latch `thr_q`.
  - `start_i` with `cfg_en_i` = 0 is ignored.
- **RUN, on `tick_i`:**
  - If `cnt` == period−1: event; `cnt` ← 0. In one-shot, → DONE. In periodic, stay in RUN.
  - Otherwise `cnt` ← `cnt` + 1.
  - No tick: `cnt` holds.
- **RUN, `start_i` (`cfg_en_i` high).** Restart: `cnt` ← 0, re-latch `thr_q`. Any `tick_i` in the same cycle is discarded; no event.
- **DONE.** `cnt` holds 0. `start_i` & `cfg_en_i` → RUN, as from IDLE.
- **Enable drop.** `cfg_en_i` low in RUN or DONE → IDLE next cycle, `cnt` ← 0. This has priority over `tick_i` and `start_i`. `irq_o` and `miss_o` are not affected.
- **Interrupt set/clear:**
  - An event sets `irq_o`.
  - `irq_ack_i` clears `irq_o`.
  - Event and ack in the same cycle: `irq_o` stays 1 and no miss is counted; the ack consumed the old event.
  - Event while `irq_o` = 1 and no ack: `miss_o` += 1, saturating at 2^MISS_WIDTH−1.
- **Miss clear.** `miss_clr_i` clears `miss_o` to 0. Clear in the same cycle as a miss increment gives 1.
- **Arithmetic.** `cnt` never exceeds period−1, so there is no wrap-around beyond the threshold compare. Compare is unsigned, full CNT_WIDTH.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Accepted `start_i` at edge N: `busy_o` = 1 and `cnt_o` = 0 from cycle N+1. The first countable tick is at N+1 or later.
- Final tick of a period sampled at edge N:
  - `irq_o` = 1 and `cnt_o` = 0 from N+1.
  - One-shot: `busy_o` = 0 from N+1.
- `irq_ack_i` at edge N: `irq_o` = 0 from N+1, unless an event also occurs at N.
- Periodic throughput: with `tick_i` held high, one event every period cycles. Period 1 gives an event every cycle.
- Asynchronous reset mid-RUN: all outputs 0 immediately. The state machine resumes only on a new `start_i` after reset release.

## Test plan
- **One-shot basic.** Threshold 5, one-shot, start, then 5 ticks spaced 3 cycles apart → `cnt_o` 1,2,3,4,0. `irq_o` rises 1 cycle after the 5th tick; `busy_o` falls the same cycle. Further ticks do not change `cnt_o` or `irq_o`.
- **Periodic with ack.** Threshold 3, periodic, `tick_i` held high for 9 cycles, ack each event 1 cycle after `irq_o` rises → 3 events, `miss_o` = 0, `busy_o` stays 1.
- **Missed events and saturation.** MISS_WIDTH 8, threshold 1, periodic, `tick_i` high for 300 cycles, no ack → `miss_o` increments to 255 and holds. `miss_clr_i` → 0. Event coinciding with ack → `irq_o` stays 1, `miss_o` unchanged.
- **Restart and threshold 0.** Threshold 4, 2 ticks, then `start_i` with `tick_i` high and new threshold 0 → `cnt_o` = 0, no event that cycle. Each subsequent tick produces an event.
- **Enable drop and reset.**
  - `cfg_en_i` low mid-RUN with `irq_o` pending → IDLE, `cnt_o` = 0, `irq_o` still 1.
  - `start_i` while disabled → ignored.
  - Assert `rst_n_i` mid-RUN → all outputs 0 asynchronously.
